// File: rtl/float_div_seq_pkg.sv
// Shared definitions for the iterative floating-point divider.
// Holds default field widths, FSM state encoding and exponent helpers
// (bias and saturated-max exponent) used by float_div_seq.
package float_div_seq_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_WIDTH_EXP = 8;
  localparam int unsigned DEF_WIDTH_MAT = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2
  } state_e;

  // Exponent bias: 2^(we-1)-1
  function automatic int unsigned exp_bias(input int unsigned we);
    return (32'd1 << (we - 32'd1)) - 32'd1;
  endfunction

  // Largest finite exponent code used for saturation: 2^we-2
  function automatic int unsigned exp_sat(input int unsigned we);
    return (32'd1 << we) - 32'd2;
  endfunction

  // Exponent value at or above which the result saturates: 2^we-1
  function automatic int unsigned exp_ovf(input int unsigned we);
    return (32'd1 << we) - 32'd1;
  endfunction

endpackage

// File: rtl/float_div_mant_core.sv
// Restoring mantissa divider, one quotient bit per step.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   load_i        load dividend mantissa into remainder, clear quotient/count
//   step_i        perform one restoring iteration
//   m1_i, m2_i    dividend / divisor mantissas including hidden bit
//   quot_o        quotient shift register, MSB-first
//   last_o        high while the next step is the final iteration
module float_div_mant_core
  import float_div_seq_pkg::*;
#(
  parameter int unsigned MW = DEF_WIDTH_MAT + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [MW-1:0] m1_i,
  input  logic [MW-1:0] m2_i,
  output logic [MW:0]   quot_o,
  output logic          last_o
);

  localparam int unsigned QW = MW + 1;
  localparam int unsigned CW = $clog2(QW + 1);

  logic [QW-1:0] rem_q, rem_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [QW-1:0] diff_c;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          ge_c;

  // Remainder stays below 2*M2, so the shifted remainder fits in QW bits
  always_comb begin
    ge_c   = (rem_q >= QW'(m2_i));
    diff_c = ge_c ? (rem_q - QW'(m2_i)) : rem_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      rem_d  = QW'(m1_i);
      quot_d = '0;
      cnt_d  = '0;
    end else if (step_i) begin
      rem_d  = diff_c << 1;
      quot_d = {quot_q[QW-2:0], ge_c};
      cnt_d  = cnt_q + CW'(1);
    end
    last_d = (cnt_d == CW'(QW - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign quot_o = quot_q;
  assign last_o = last_q;

endmodule

// File: rtl/float_div_seq.sv
// Iterative floating-point divider: result = OP1 / OP2 on the
// sign | biased exponent | hidden-1 mantissa format, truncating.
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   start         request, sampled only when idle
//   OP1, OP2      dividend, divisor
//   exce_in       upstream exception, ORed into exce_out
//   busy          operation in progress
//   done          one-cycle completion pulse
//   exce_out      exception flag for the current result
//   result        quotient, held until next completion or reset
module float_div_seq
  import float_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned WIDTH_exp = DEF_WIDTH_EXP,
  parameter int unsigned WIDTH_mat = DEF_WIDTH_MAT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic             exce_in,
  output logic             busy,
  output logic             done,
  output logic             exce_out,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned MW   = WIDTH_mat + 1;
  localparam int unsigned QW   = WIDTH_mat + 2;
  localparam int unsigned EW   = WIDTH_exp + 2;
  localparam int unsigned BIAS = exp_bias(WIDTH_exp);
  localparam logic signed [EW-1:0] EOVF = EW'(exp_ovf(WIDTH_exp));
  localparam logic [WIDTH-1:0] SAT_MAG =
    {1'b0, WIDTH_exp'(exp_sat(WIDTH_exp)), {WIDTH_mat{1'b1}}};

  // Operand fields
  logic                 sign1_c, sign2_c;
  logic [WIDTH_exp-1:0] exp1_c, exp2_c;
  logic [WIDTH_mat-1:0] man1_c, man2_c;
  logic                 zero1_c, zero2_c;

  assign sign1_c = OP1[WIDTH-1];
  assign sign2_c = OP2[WIDTH-1];
  assign exp1_c  = OP1[WIDTH-2 -: WIDTH_exp];
  assign exp2_c  = OP2[WIDTH-2 -: WIDTH_exp];
  assign man1_c  = OP1[WIDTH_mat-1:0];
  assign man2_c  = OP2[WIDTH_mat-1:0];
  assign zero1_c = (exp1_c == '0) && (man1_c == '0);
  assign zero2_c = (exp2_c == '0) && (man2_c == '0);

  state_e state_q, state_d;

  logic                 sign_q;
  logic                 exce_in_q;
  logic [WIDTH_exp-1:0] exp1_q, exp2_q;
  logic                 div0_q, zero1_q;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 exce_q, exce_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 core_load_c, core_step_c;
  logic [QW-1:0]        quot_c;
  logic                 core_last_c;

  logic signed [EW-1:0] exp_c;
  logic [WIDTH_mat-1:0] mant_c;
  logic                 ovf_c, unf_c;

  float_div_mant_core #(
    .MW(MW)
  ) u_core (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (core_load_c),
    .step_i (core_step_c),
    .m1_i   ({1'b1, man1_c}),
    .m2_i   ({1'b1, man2_c}),
    .quot_o (quot_c),
    .last_o (core_last_c)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; zero operands bypass DIV and finish through NORM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (zero1_c || zero2_c) ? ST_NORM : ST_DIV;
      ST_DIV:  if (core_last_c) state_d = ST_NORM;
      ST_NORM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Normalisation of the quotient (MSB is the integer bit)
  always_comb begin
    exp_c  = EW'(exp1_q) - EW'(exp2_q) + EW'(BIAS) - EW'(!quot_c[QW-1]);
    mant_c = quot_c[QW-1] ? quot_c[WIDTH_mat:1] : quot_c[WIDTH_mat-1:0];
    ovf_c  = (exp_c >= EOVF);
    unf_c  = exp_c[EW-1] || (exp_c == '0);
  end

  // Output / control decode
  always_comb begin
    core_load_c = 1'b0;
    core_step_c = 1'b0;
    done_d      = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    exce_d      = exce_q;
    result_d    = result_q;
    case (state_q)
      ST_IDLE: core_load_c = start;
      ST_DIV:  core_step_c = 1'b1;
      ST_NORM: begin
        done_d = 1'b1;
        if (div0_q) begin
          result_d = SAT_MAG | {sign_q, {(WIDTH-1){1'b0}}};
          exce_d   = 1'b1;
        end else if (zero1_q) begin
          result_d = '0;
          exce_d   = exce_in_q;
        end else if (ovf_c) begin
          result_d = SAT_MAG | {sign_q, {(WIDTH-1){1'b0}}};
          exce_d   = 1'b1;
        end else if (unf_c) begin
          result_d = '0;
          exce_d   = 1'b1;
        end else begin
          result_d = {sign_q, exp_c[WIDTH_exp-1:0], mant_c};
          exce_d   = exce_in_q;
        end
      end
      default: ;
    endcase
  end

  // Operand capture and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      sign_q    <= 1'b0;
      exce_in_q <= 1'b0;
      exp1_q    <= '0;
      exp2_q    <= '0;
      div0_q    <= 1'b0;
      zero1_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exce_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      if (core_load_c) begin
        sign_q    <= sign1_c ^ sign2_c;
        exce_in_q <= exce_in;
        exp1_q    <= exp1_c;
        exp2_q    <= exp2_c;
        div0_q    <= zero2_c;
        zero1_q   <= zero1_c;
      end
      busy_q   <= busy_d;
      done_q   <= done_d;
      exce_q   <= exce_d;
      result_q <= result_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign exce_out = exce_q;
  assign result   = result_q;

endmodule
